// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with a
// double-buffered value. Define SEG_SCAN_LZ_BLANK_EN to blank leading-zero digits.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES   = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic                    pending,
  output logic                    frame_done,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel_n
);

  localparam int unsigned MaxCnt = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW     = 4 * NUM_DIGITS;

  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);
  localparam bit              HasGap    = (GAP_CYCLES != 0);
  localparam logic [6:0]      Blank     = 7'h7F;

  typedef enum logic [1:0] {StOff, StShow, StGap} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  next_digit;
  logic [3:0]            nib;

  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SEG_SCAN_LZ_BLANK_EN
  // upper_zero[i]: every nibble from digit i upward is zero
  logic [NUM_DIGITS-1:0] upper_zero;
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      upper_zero[i] = ((active_d >> (4 * i)) == '0);
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    next_digit   = 1'b0;

    unique case (state_q)
      StOff: begin
        if (load) begin
          active_d  = value_in;
          shadow_d  = value_in;
          pending_d = 1'b0;
        end
        if (enable) begin
          state_d = StShow;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      StShow, StGap: begin
        if (load) begin
          shadow_d  = value_in;
          pending_d = 1'b1;
        end
        if (!enable) begin
          state_d = StOff;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (state_q == StShow && cnt_q != DwellLast) begin
          cnt_d = cnt_q + 1'b1;
        end else if (state_q == StShow && HasGap) begin
          state_d = StGap;
          cnt_d   = '0;
        end else if (state_q == StGap && cnt_q != GapLast) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          next_digit = 1'b1;
        end
      end
      default: state_d = StOff;
    endcase

    if (next_digit) begin
      state_d = StShow;
      cnt_d   = '0;
      if (idx_q != IdxLast) begin
        idx_d = idx_q + 1'b1;
      end else begin
        // Frame boundary: a load on this very edge bypasses the shadow
        idx_d        = '0;
        frame_done_d = 1'b1;
        active_d     = load ? value_in : shadow_q;
        pending_d    = 1'b0;
      end
    end

    // Outputs are computed from next state so they change with the state entry
    seg_d = Blank;
    sel_d = '1;
    nib   = active_d[4*idx_d +: 4];
    if (state_d == StShow) begin
      sel_d[idx_d] = 1'b0;
      seg_d        = decode(nib);
`ifdef SEG_SCAN_LZ_BLANK_EN
      if (idx_d != '0 && upper_zero[idx_d]) seg_d = Blank;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StOff;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= Blank;
      sel_q        <= '1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;
  assign seg        = seg_q;
  assign dig_sel_n  = sel_q;

endmodule
